// File: rtl/dca_matrix_register_type2.sv
// dca_matrix_register_type2
//   ROW x COL tile register for DCA tensor operands. Rows stream in from the
//   bottom and out from the top, using valid/ready handshakes. The block also
//   supports a whole-matrix write, a left shift with right-edge fill, and a
//   single-cycle transpose. The transpose applies to square tiles only.
//
//   Optional feature macro: DCA_MATRIX_REGISTER_TYPE2_RECIRC_EN.
//   When it is defined, a store beat with store_recirc=1 writes the outgoing
//   row back in at the bottom. If every beat of a pass recirculates, the
//   matrix is preserved.
//
// Ports
//   clk, rstnn                 clock, synchronous active-high reset
//   init                       synchronous clear to INIT_VALUE (aborts streams)
//   load_valid/ready/data      row-in stream; element c at [c*BW+:BW]
//   store_valid/ready/data     row-out stream; store_data is row 0
//   store_recirc               recirculate the outgoing row (feature macro)
//   all_wenable/all_wdata      parallel write of the whole matrix
//   shift_left/rightmost_wdata shift columns left; fill the right edge per row
//   transpose                  element[r][c] <= element[c][r]
//   all_rdata_list2d           full matrix; row r at [r*BW_ROW+:BW_ROW]
//   row_count, empty, full     fill level
//   op_error                   sticky illegal-command flag
module dca_matrix_register_type2 #(
  parameter int MATRIX_NUM_ROW   = 8,
  parameter int MATRIX_NUM_COL   = 8,
  parameter int BW_TENSOR_SCALAR = 32,
  parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE = '0,
  parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE  = RESET_VALUE,
  localparam int BW_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
  localparam int BW_MATRIX = MATRIX_NUM_ROW * BW_ROW,
  localparam int BW_CNT    = $clog2(MATRIX_NUM_ROW + 1)
) (
  input  logic                                     clk,
  input  logic                                     rstnn,
  input  logic                                     init,
  input  logic                                     load_valid,
  output logic                                     load_ready,
  input  logic [BW_ROW-1:0]                        load_data,
  output logic                                     store_valid,
  input  logic                                     store_ready,
  output logic [BW_ROW-1:0]                        store_data,
  input  logic                                     store_recirc,
  input  logic                                     all_wenable,
  input  logic [BW_MATRIX-1:0]                     all_wdata_list2d,
  input  logic                                     shift_left,
  input  logic [MATRIX_NUM_ROW*BW_TENSOR_SCALAR-1:0] rightmost_wdata_list1d,
  input  logic                                     transpose,
  output logic [BW_MATRIX-1:0]                     all_rdata_list2d,
  output logic [BW_CNT-1:0]                        row_count,
  output logic                                     empty,
  output logic                                     full,
  output logic                                     op_error
);
  localparam int R  = MATRIX_NUM_ROW;
  localparam int C  = MATRIX_NUM_COL;
  localparam int BW = BW_TENSOR_SCALAR;
  localparam bit SQUARE = (R == C);
  localparam logic [BW_CNT-1:0] CNT_FULL = BW_CNT'(R);
  localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(R - 1);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_LOADING = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_STORING = 2'd3;

  typedef logic [R-1:0][C-1:0][BW-1:0] mat_t;

  mat_t              mat_q, mat_d, mat_up, mat_tr, mat_shl;
  logic [1:0]        state_q, state_d;
  logic [BW_CNT-1:0] cnt_q, cnt_d, sent_q, sent_d;
  logic              allrc_q, allrc_d;   // every store beat so far recirculated
  logic              err_q, err_d;
  logic              recirc, direct_ok, any_direct, op_take, op_bad;
  logic              load_hs, store_hs;

`ifdef DCA_MATRIX_REGISTER_TYPE2_RECIRC_EN
  assign recirc = store_recirc;
`else
  logic unused_recirc;
  assign unused_recirc = store_recirc;
  assign recirc        = 1'b0;
`endif

  // Direct ops are only accepted between streams. When one takes effect it
  // owns the cycle, so ready/valid drop and no handshake is lost.
  assign direct_ok  = (state_q == S_EMPTY) || (state_q == S_FULL);
  assign any_direct = all_wenable | transpose | shift_left;
  assign op_take    = direct_ok & (all_wenable | (transpose ? SQUARE : shift_left));
  assign op_bad     = (any_direct & ~direct_ok) |
                      (direct_ok & ~all_wenable & transpose & ~SQUARE);

  assign load_ready  = ((state_q == S_EMPTY) || (state_q == S_LOADING)) & ~op_take;
  assign store_valid = ((state_q == S_FULL)  || (state_q == S_STORING)) & ~op_take;
  assign load_hs     = load_valid & load_ready;
  assign store_hs    = store_valid & store_ready;

  // Row shift-up shared by load and store. The bottom row takes the new row,
  // the recirculated top row, or the reset value.
  always_comb begin
    mat_up = mat_q;
    for (int r = 0; r < R - 1; r++) mat_up[r] = mat_q[r + 1];
    mat_up[R-1] = load_hs ? load_data : (recirc ? mat_q[0] : {C{RESET_VALUE}});
  end

  generate
    if (SQUARE) begin : g_tr
      always_comb begin
        mat_tr = mat_q;
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++) mat_tr[r][c] = mat_q[c][r];
      end
    end else begin : g_notr
      assign mat_tr = mat_q;
    end
  endgenerate

  always_comb begin
    mat_shl = mat_q;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C - 1; c++) mat_shl[r][c] = mat_q[r][c + 1];
      mat_shl[r][C-1] = rightmost_wdata_list1d[r*BW +: BW];
    end
  end

  always_comb begin
    mat_d   = mat_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    allrc_d = allrc_q;
    err_d   = err_q | op_bad;
    if (init) begin
      mat_d   = {(R*C){INIT_VALUE}};
      state_d = S_EMPTY;
      cnt_d   = '0;
      sent_d  = '0;
      allrc_d = 1'b1;
      err_d   = 1'b0;
    end else if (op_take) begin
      if (all_wenable) begin
        mat_d   = all_wdata_list2d;
        state_d = S_FULL;
        cnt_d   = CNT_FULL;
        sent_d  = '0;
        allrc_d = 1'b1;
      end else if (transpose) begin
        mat_d = mat_tr;
      end else begin
        mat_d = mat_shl;
      end
    end else if (load_hs) begin
      mat_d   = mat_up;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CNT_LAST) ? S_FULL : S_LOADING;
    end else if (store_hs) begin
      mat_d   = mat_up;
      sent_d  = sent_q + 1'b1;
      allrc_d = allrc_q & recirc;
      if (!recirc) cnt_d = cnt_q - 1'b1;
      state_d = S_STORING;
      // A pass ends after ROW beats. The matrix survives only when every
      // beat of the pass recirculated.
      if (sent_q == CNT_LAST) begin
        sent_d  = '0;
        allrc_d = 1'b1;
        if (allrc_q & recirc) begin
          state_d = S_FULL;
        end else begin
          state_d = S_EMPTY;
          cnt_d   = '0;
          mat_d   = {(R*C){RESET_VALUE}};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstnn) begin
      mat_q   <= {(R*C){RESET_VALUE}};
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      sent_q  <= '0;
      allrc_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      mat_q   <= mat_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      allrc_q <= allrc_d;
      err_q   <= err_d;
    end
  end

  assign store_data       = mat_q[0];
  assign all_rdata_list2d = mat_q;
  assign row_count        = cnt_q;
  assign empty            = (cnt_q == '0);
  assign full             = (cnt_q == CNT_FULL);
  assign op_error         = err_q;
endmodule

// File: tb/tb_dca_matrix_register_type2.sv
module tb_dca_matrix_register_type2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // 4x4x8 square instance (INIT_VALUE differs from RESET_VALUE)
  logic         rstnn, s_init, s_lv, s_lr, s_sv, s_sr, s_rc, s_we, s_shl, s_tr;
  logic [31:0]  s_ld, s_sd, s_fill;
  logic [127:0] s_wd, s_rd;
  logic [2:0]   s_cnt;
  logic         s_empty, s_full, s_err;

  // 2x3x8 non-square instance
  logic         n_init, n_lv, n_lr, n_sv, n_sr, n_rc, n_we, n_shl, n_tr;
  logic [23:0]  n_ld, n_sd;
  logic [15:0]  n_fill;
  logic [47:0]  n_wd, n_rd;
  logic [1:0]   n_cnt;
  logic         n_empty, n_full, n_err;

  dca_matrix_register_type2 #(
    .MATRIX_NUM_ROW(4), .MATRIX_NUM_COL(4), .BW_TENSOR_SCALAR(8),
    .RESET_VALUE(8'h00), .INIT_VALUE(8'h5A)
  ) u_sq (
    .clk(clk), .rstnn(rstnn), .init(s_init),
    .load_valid(s_lv), .load_ready(s_lr), .load_data(s_ld),
    .store_valid(s_sv), .store_ready(s_sr), .store_data(s_sd), .store_recirc(s_rc),
    .all_wenable(s_we), .all_wdata_list2d(s_wd),
    .shift_left(s_shl), .rightmost_wdata_list1d(s_fill), .transpose(s_tr),
    .all_rdata_list2d(s_rd), .row_count(s_cnt), .empty(s_empty), .full(s_full),
    .op_error(s_err)
  );

  dca_matrix_register_type2 #(
    .MATRIX_NUM_ROW(2), .MATRIX_NUM_COL(3), .BW_TENSOR_SCALAR(8)
  ) u_ns (
    .clk(clk), .rstnn(rstnn), .init(n_init),
    .load_valid(n_lv), .load_ready(n_lr), .load_data(n_ld),
    .store_valid(n_sv), .store_ready(n_sr), .store_data(n_sd), .store_recirc(n_rc),
    .all_wenable(n_we), .all_wdata_list2d(n_wd),
    .shift_left(n_shl), .rightmost_wdata_list1d(n_fill), .transpose(n_tr),
    .all_rdata_list2d(n_rd), .row_count(n_cnt), .empty(n_empty), .full(n_full),
    .op_error(n_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rows [4];
  logic [31:0] m    [4];
  bit   [4:0]  pat;
  int          idx;

  initial begin
    rows = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    m    = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    rstnn = 1'b1;
    {s_init, s_lv, s_sr, s_rc, s_we, s_shl, s_tr} = '0;
    {n_init, n_lv, n_sr, n_rc, n_we, n_shl, n_tr} = '0;
    s_ld = '0; s_fill = '0; s_wd = '0;
    n_ld = '0; n_fill = '0; n_wd = '0;
    tick(); tick();
    rstnn = 1'b0;

    // reset state
    chk("rst_cnt",   128'(s_cnt), 128'd0);
    chk("rst_ready", 128'(s_lr),  128'd1);
    chk("rst_valid", 128'(s_sv),  128'd0);
    chk("rst_empty", 128'(s_empty), 128'd1);
    chk("rst_err",   128'(s_err), 128'd0);
    chk("rst_mat",   s_rd, 128'd0);

    // stream 4 rows in
    for (int i = 0; i < 4; i++) begin
      s_lv = 1'b1; s_ld = rows[i];
      tick();
      if (i == 0) begin
        chk("ld1_bottom", 128'(s_rd[127:96]), 128'(32'h04030201));
        chk("ld1_cnt",    128'(s_cnt), 128'd1);
      end
    end
    s_lv = 1'b0;
    chk("ld_full",  128'(s_full), 128'd1);
    chk("ld_ready", 128'(s_lr),   128'd0);
    chk("ld_row0",  128'(s_rd[31:0]), 128'(32'h04030201));
    chk("ld_cnt",   128'(s_cnt), 128'd4);
    chk("ld_mat",   s_rd, {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201});

    // stream out with store_ready 1,0,1,1,1
    pat = 5'b11101;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      s_sr = pat[i];
      chk("st_data", 128'(s_sd), 128'(rows[idx]));
      chk("st_valid", 128'(s_sv), 128'd1);
      tick();
      if (pat[i]) idx++;
    end
    s_sr = 1'b0;
    chk("st_empty", 128'(s_empty), 128'd1);
    chk("st_valid_end", 128'(s_sv), 128'd0);
    chk("st_ready_end", 128'(s_lr), 128'd1);
    chk("st_mat_end", s_rd, 128'd0);

    // whole-matrix write of identity, then transpose
    s_we = 1'b1; s_wd = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    tick();
    s_we = 1'b0;
    chk("we_mat",  s_rd, {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001});
    chk("we_full", 128'(s_full), 128'd1);
    s_tr = 1'b1;
    tick();
    s_tr = 1'b0;
    chk("tr_ident", s_rd, {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001});

    // init from FULL
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    chk("init_cnt", 128'(s_cnt), 128'd0);
    chk("init_mat", s_rd, {16{8'h5A}});

    // load element values column-major (element[r][c] = r + 4c), then transpose
    for (int r = 0; r < 4; r++) begin
      s_lv = 1'b1;
      s_ld = {8'(r + 12), 8'(r + 8), 8'(r + 4), 8'(r)};
      tick();
    end
    s_lv = 1'b0;
    s_tr = 1'b1;
    tick();
    s_tr = 1'b0;
    chk("tr_e10", 128'(s_rd[39:32]), 128'd4);
    chk("tr_e01", 128'(s_rd[15:8]),  128'd1);
    chk("tr_mat", s_rd, {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100});
    chk("tr_err", 128'(s_err), 128'd0);

    // shift_left during LOADING is ignored and flagged; the load proceeds
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    s_lv = 1'b1; s_ld = 32'h11223344; tick();
    s_ld = 32'h55667788; tick();
    s_ld = 32'h99AABBCC; s_shl = 1'b1; s_fill = 32'hFFFFFFFF; tick();
    s_lv = 1'b0; s_shl = 1'b0;
    chk("shl_ld_mat", s_rd, {32'h99AABBCC, 32'h55667788, 32'h11223344, 32'h5A5A5A5A});
    chk("shl_ld_err", 128'(s_err), 128'd1);
    chk("shl_ld_cnt", 128'(s_cnt), 128'd3);
    chk("shl_ld_rdy", 128'(s_lr),  128'd1);
    s_init = 1'b1;
    tick();
    s_init = 1'b0;
    chk("init2_err", 128'(s_err), 128'd0);
    chk("init2_cnt", 128'(s_cnt), 128'd0);
    chk("init2_mat", s_rd, {16{8'h5A}});

    // non-square: transpose is rejected, shift_left works
    n_lv = 1'b1; n_ld = 24'h030201; tick();
    n_ld = 24'h060504; tick();
    n_lv = 1'b0;
    chk("ns_full", 128'(n_full), 128'd1);
    n_tr = 1'b1;
    tick();
    n_tr = 1'b0;
    chk("ns_tr_err", 128'(n_err), 128'd1);
    chk("ns_tr_mat", 128'(n_rd),  128'(48'h060504_030201));
    chk("ns_tr_full", 128'(n_full), 128'd1);
    n_shl = 1'b1; n_fill = {8'hBB, 8'hAA};
    tick();
    n_shl = 1'b0;
    chk("ns_shl_mat", 128'(n_rd), 128'(48'hBB0605_AA0302));
    chk("ns_shl_err", 128'(n_err), 128'd1);
    chk("ns_shl_cnt", 128'(n_cnt), 128'd2);

    // store with store_recirc=1 on every beat
    s_we = 1'b1; s_wd = {m[3], m[2], m[1], m[0]};
    tick();
    s_we = 1'b0;
    s_sr = 1'b1; s_rc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rc_data", 128'(s_sd), 128'(m[i]));
      tick();
`ifdef DCA_MATRIX_REGISTER_TYPE2_RECIRC_EN
      if (i == 1) chk("rc_cnt_mid", 128'(s_cnt), 128'd4);
`else
      if (i == 1) chk("rc_cnt_mid", 128'(s_cnt), 128'd2);
`endif
    end
    s_sr = 1'b0; s_rc = 1'b0;
`ifdef DCA_MATRIX_REGISTER_TYPE2_RECIRC_EN
    chk("rc_full",  128'(s_full), 128'd1);
    chk("rc_valid", 128'(s_sv),   128'd1);
    chk("rc_mat",   s_rd, {m[3], m[2], m[1], m[0]});
`else
    chk("rc_empty", 128'(s_empty), 128'd1);
    chk("rc_valid", 128'(s_sv),    128'd0);
    chk("rc_mat",   s_rd, 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/dca_matrix_register_type2.md
Name: dca_matrix_register_type2

Overview:
Parametrised successor of the type-1 DCA matrix register.
- Non-square ROW x COL tile register for DCA tensor operands.
- Row streaming in and out uses valid/ready handshakes, tracked by a row counter and a fill-state FSM.
- Also supports whole-matrix write, left shift with right-edge fill, and single-cycle transpose.
- Sits between the DCA tensor DMA row streams and the compute array, which reads all_rdata_list2d in parallel.

Parameters:
MATRIX_NUM_ROW, 8, number of rows (>=2)
MATRIX_NUM_COL, 8, number of columns (>=1)
BW_TENSOR_SCALAR, 32, bits per element
RESET_VALUE, 0, element value on reset
INIT_VALUE, RESET_VALUE, element value on init
Derived: BW_ROW=COL*BW_TENSOR_SCALAR; BW_MATRIX=ROW*BW_ROW; BW_CNT=clog2(ROW+1)

Ports:
clk  in  1  clock
rstnn  in  1  reset, synchronous, active-high (asserted = 1; codebase port name kept)
init  in  1  synchronous clear to INIT_VALUE
load_valid  in  1  row-in valid
load_ready  out  1  row-in ready
load_data  in  BW_ROW  row in; element c at [c*BW+:BW]
store_valid  out  1  row-out valid
store_ready  in  1  row-out ready
store_data  out  BW_ROW  current upmost row
store_recirc  in  1  write stored row back at bottom (optional feature)
all_wenable  in  1  parallel write of whole matrix
all_wdata_list2d  in  BW_MATRIX  row r at [r*BW_ROW+:BW_ROW]
shift_left  in  1  shift all rows left by one element
rightmost_wdata_list1d  in  ROW*BW  fill column, one element per row
transpose  in  1  transpose (square only)
all_rdata_list2d  out  BW_MATRIX  full matrix
row_count  out  BW_CNT  valid rows held
empty  out  1  row_count==0
full  out  1  row_count==ROW
op_error  out  1  sticky illegal-command flag

Behaviour:
- Reset: all elements = RESET_VALUE; state EMPTY; row_count=0; op_error=0; load_ready=1; store_valid=0.
- FSM states: EMPTY, LOADING, FULL, STORING.
  - EMPTY->LOADING on first load handshake.
  - LOADING->FULL when the ROW-th row is accepted.
  - FULL->STORING on first store handshake.
  - STORING->EMPTY when the ROW-th row is sent.
  - ROW==1: EMPTY->FULL and FULL->EMPTY directly.
- Load handshake = load_valid & load_ready.
  - load_ready=1 only in EMPTY/LOADING.
  - On handshake: all rows shift up by one; load_data written to the downmost row; row_count+1.
  - Row loaded first ends at row 0 after ROW beats.
- Store handshake = store_valid & store_ready.
  - store_valid=1 only in FULL/STORING.
  - store_data = row 0, combinational from the register.
  - On handshake: rows shift up; downmost row gets RESET_VALUE; row_count-1.
- Latency: a loaded row is visible on all_rdata the cycle after its handshake; store_data changes the cycle after a handshake.
- Load and store never occur in the same cycle (ready/valid are state-exclusive).
- Direct ops are legal only in EMPTY or FULL. Priority: rstnn > init > all_wenable > transpose > shift_left > stream handshake.
  - all_wenable: whole matrix written, row_count=ROW, state FULL.
  - transpose: element[r][c] <= element[c][r] in one cycle; state unchanged. If ROW!=COL, ignored and op_error set.
  - shift_left: column c <= column c+1; rightmost column <= rightmost_wdata_list1d; state unchanged.
  - Any direct op in LOADING/STORING is ignored and sets op_error; an accompanying handshake still proceeds.
- init: all elements = INIT_VALUE; state EMPTY; row_count=0; op_error cleared. Allowed in any state, including mid-stream; aborts the stream.
- Simultaneous direct ops: only the highest-priority one takes effect; the lower ones are dropped without setting op_error.

Optional Feature:
Macro DCA_MATRIX_REGISTER_TYPE2_RECIRC_EN.
- Defined: on a store handshake with store_recirc=1, the downmost row gets the outgoing row 0 instead of RESET_VALUE and row_count is unchanged. When ROW rows have been sent, the state returns to FULL, not EMPTY, so the matrix is preserved for reuse. The recirc decision is sampled per beat; mixed beats are allowed, but the final state is FULL only if every beat recirculated, otherwise EMPTY with the remaining rows reset.
- Undefined: the store_recirc port exists but is ignored; behaviour is as with store_recirc=0.

Test Plan:
- ROW=COL=4, BW=8: reset, then load rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D with load_valid=1 -> full=1 after 4th beat, load_ready=0, row 0 = 0x04030201, row_count=4.
- From full: store 4 beats with store_ready toggling 1,0,1,1,1 -> store_data sequence 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; no beat while ready=0; empty=1 after the last beat.
- all_wenable with identity matrix, then transpose -> identity unchanged. Load rows 0..15 as elements, then transpose -> element[1][0]=4, element[0][1]=1.
- Assert shift_left during LOADING (2 rows in) -> matrix unchanged by the shift, op_error=1, load continues; init -> op_error=0, row_count=0, all elements = INIT_VALUE.
- ROW=2, COL=3 transpose in FULL -> ignored, op_error=1. shift_left with fill {0xAA,0xBB} -> rightmost column = AA/BB, other columns shifted left.
- With RECIRC_EN: 4 store beats with store_recirc=1 -> same 4 rows output, state FULL, all_rdata equal to pre-store matrix.
